// File: rtl/fifo_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_ctrl_if
// Handshake bundle for fifo_ctrl: the producer-side stream (in_*) and the
// consumer-side stream (out_*).
//   slave  : the FIFO controller (accepts in_*, presents out_*)
//   master : the environment (producer + consumer) driving the FIFO
// Parameters:
//   DWIDTH : data word width
// ----------------------------------------------------------------------------
interface fifo_ctrl_if #(
    parameter int DWIDTH = 25
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fifo_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ctrl
// Single-clock FIFO controller for an external dual-port array with
// combinational read. Holds the write/read pointers, occupancy, flags and
// flush logic, and presents valid/ready streams on both sides.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   flush        : synchronous clear of all contents
//   bus          : fifo_ctrl_if.slave (in_valid/in_ready/in_data,
//                  out_valid/out_ready/out_data)
//   mem_wen      : array write enable (combinational from push)
//   mem_waddr    : array write address
//   mem_wdata    : array write data (= in_data)
//   mem_raddr    : array read address
//   mem_rdata    : array combinational read data
//   count        : occupancy, 0..capacity
//   almost_full  : count >= AF_LEVEL (registered)
//   almost_empty : count <= AE_LEVEL (registered)
//
// Build option:
//   FIFO_CTRL_OREG_EN : adds a one-entry output register between the array
//                       and out_data (capacity DEPTH+1, 2-cycle latency).
//                       Undefined: first-word fall-through from the array.
// ----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int DWIDTH   = 25,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    fifo_ctrl_if.slave        bus,
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [AWIDTH-1:0] mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [AWIDTH:0]   count,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam logic [AWIDTH:0] L_AF  = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] L_AE  = (AWIDTH+1)'(AE_LEVEL);
    localparam logic [AWIDTH:0] L_ONE = (AWIDTH+1)'(1);

    logic [AWIDTH:0] r_wptr;
    logic [AWIDTH:0] r_rptr;
    logic [AWIDTH:0] r_count;
    logic            r_af;
    logic            r_ae;

    logic            w_run;       // neither reset nor flush this cycle
    logic            w_empty;     // array holds no words
    logic            w_full;      // array holds DEPTH words
    logic            w_push;
    logic            w_pop;
    logic            w_radv;      // read pointer advances
    logic [AWIDTH:0] w_count_nxt;

    assign w_run   = rst_n & ~flush;
    assign w_empty = (r_wptr == r_rptr);
    // Same slot, opposite lap: the writer is a full lap ahead.
    assign w_full  = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                     (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);

    assign bus.in_ready = ~w_full & w_run;
    assign w_push       = bus.in_valid & bus.in_ready;
    // A handshake seen during reset or flush is discarded, not counted.
    assign w_pop        = bus.out_valid & bus.out_ready & w_run;

    assign mem_wen   = w_push;
    assign mem_waddr = r_wptr[AWIDTH-1:0];
    assign mem_wdata = bus.in_data;
    assign mem_raddr = r_rptr[AWIDTH-1:0];

`ifdef FIFO_CTRL_OREG_EN
    logic              r_oreg_valid;
    logic [DWIDTH-1:0] r_oreg_data;
    logic              w_load;

    // Refill the output register whenever it is, or is about to become, free.
    assign w_load        = ~w_empty & (~r_oreg_valid | w_pop) & w_run;
    assign w_radv        = w_load;
    assign bus.out_valid = r_oreg_valid;
    assign bus.out_data  = r_oreg_data;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_oreg_valid <= 1'b0;
        end else if (w_load) begin
            r_oreg_valid <= 1'b1;
        end else if (w_pop) begin
            r_oreg_valid <= 1'b0;
        end
    end

    // NOTE: the data register carries no reset; r_oreg_valid qualifies it,
    // so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_oreg_data <= mem_rdata;
        end
    end
`else
    assign w_radv        = w_pop;
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = mem_rdata;
`endif

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + L_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - L_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + L_ONE;
            end
            if (w_radv) begin
                r_rptr <= r_rptr + L_ONE;
            end
            r_count <= w_count_nxt;
            // Flags follow the next count so they line up with count.
            r_af    <= (w_count_nxt >= L_AF);
            r_ae    <= (w_count_nxt <= L_AE);
        end
    end

    assign count        = r_count;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous single-clock FIFO controller; drives the write/read ports of the dual-port fifomem array and presents valid/ready streams on both sides.
- Upstream producer pushes through the in_* handshake; downstream consumer pops through the out_* handshake.
- Holds the pointers, occupancy, flags and flush logic; the array is external and combinational-read.

Parameters:
DWIDTH, 25, data word width; must match the fifomem instance.
AWIDTH, 4, array address width; DEPTH = 1 << AWIDTH entries.
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  synchronous active-low reset.
flush  input  1  synchronous clear of all contents; data is discarded.
in_valid  input  1  producer has a word.
in_ready  output  1  FIFO accepts a word this cycle.
in_data  input  DWIDTH  producer word.
out_valid  output  1  out_data holds the head word.
out_ready  input  1  consumer takes the head word.
out_data  output  DWIDTH  head word.
mem_wen  output  1  array write enable.
mem_waddr  output  AWIDTH  array write address.
mem_wdata  output  DWIDTH  array write data; equals in_data.
mem_raddr  output  AWIDTH  array read address.
mem_rdata  input  DWIDTH  array combinational read data.
count  output  AWIDTH+1  occupancy, 0..capacity.
almost_full  output  1  count >= AF_LEVEL.
almost_empty  output  1  count <= AE_LEVEL.

Behaviour:
- Pointers: wptr and rptr are AWIDTH+1 bits. The low AWIDTH bits address the array; the MSB is the wrap bit. Both wrap naturally at 2*DEPTH.
- mem empty when wptr == rptr.
- mem full when the low bits are equal and the MSBs differ.
- push = in_valid & in_ready. On push: mem_wen=1, mem_waddr=wptr[AWIDTH-1:0], wptr increments.
- pop = out_valid & out_ready. On pop: rptr increments.
- in_ready = !full. There is no push-through when full, even if a pop occurs in the same cycle.
- out_valid = !empty. out_data = mem_rdata and mem_raddr = rptr[AWIDTH-1:0] (first-word fall-through).
- Latency from a push into an empty FIFO to out_valid: 1 cycle.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- Push into empty with out_ready high: the word is not visible that cycle, so no pop occurs.
- count = wptr - rptr, computed modulo 2^(AWIDTH+1) and registered alongside the pointers. It updates +1, -1 or 0 per cycle.
- almost_full and almost_empty are registered and derived from the next count, so they are coherent with count every cycle.
- Reset (rst_n=0 at the edge):
  - wptr=0, rptr=0, count=0.
  - in_ready=1 after reset; it is 0 while rst_n is low.
  - out_valid=0, almost_full=0, almost_empty=1, mem_wen=0.
  - Reset mid-stream drops all contents; array contents are don't-care.
- flush=1 at the edge: same pointer/count/flag effect as reset. While flush is high: in_ready=0 and mem_wen=0, and no push or pop is counted. rst_n has priority over flush.
- No state machine beyond the pointer pair. mem_wen is combinational from push; all other outputs are registered or derived from registers.

Optional Feature:
- Macro FIFO_CTRL_OREG_EN.
- Defined:
  - A one-entry output register sits between mem_rdata and out_data, with out_valid driven from its occupancy flag.
  - The register loads from the array when it is empty, or when it is popped in the same cycle and mem is non-empty; rptr advances on each load.
  - Latency from push-into-empty to out_valid: 2 cycles. Capacity becomes DEPTH+1.
  - count includes the register entry; in_ready still reflects mem full only.
  - Reset and flush clear the register flag.
- Undefined: combinational fall-through as described above.

Test Plan:
- Reset, then push 0x0000001..0x0000010 (16 words, AWIDTH=4) with out_ready=0 → in_ready=0 after the 16th push, count=16, almost_full=1 once count reaches 12.
- From full: out_ready=1 for 16 cycles → out_data 0x0000001..0x0000010 in order, count reaches 0, out_valid=0, almost_empty=1.
- Continuous push and pop at 100% duty for 40 cycles from count=3 → count stays 3, order preserved across pointer wrap (wptr MSB toggles).
- Single push into an empty FIFO with out_ready=1 → out_valid rises exactly 1 cycle later and pops on that cycle. With FIFO_CTRL_OREG_EN, out_valid rises 2 cycles later.
- flush with count=7 during a simultaneous push → next cycle count=0, out_valid=0, the pushed word is discarded, mem_wen=0 in the flush cycle.
- rst_n=0 asserted mid-burst while full, then released → all outputs at reset values, and the first word pushed afterwards appears first at out_data.
